// File: rtl/fpn_normalize_pipe_pkg.sv
// rtl/fpn_normalize_pipe_pkg.sv - shared widths, stage record and saturation constant for the normaliser
package fpn_pkg;

    localparam int MANT_W_DEF = 24;
    localparam int EXP_W_DEF  = 8;

    function automatic int sum_w(input int mant_w);
        return mant_w + 2;
    endfunction

    function automatic int shift_w(input int mant_w);
        return $clog2(mant_w + 2);
    endfunction

    function automatic int exp_iw(input int exp_w);
        return exp_w + 2;
    endfunction

    function automatic int exp_sat(input int exp_w);
        return (1 << exp_w) - 1;
    endfunction

    localparam int SUM_W   = sum_w(MANT_W_DEF);
    localparam int SHIFT_W = shift_w(MANT_W_DEF);
    localparam int EXP_IW  = exp_iw(EXP_W_DEF);
    localparam logic [EXP_W_DEF-1:0] EXP_SAT = EXP_W_DEF'(exp_sat(EXP_W_DEF));

    typedef struct packed {
        logic                 sign;
        logic [SUM_W-1:0]     mag;
        logic [EXP_W_DEF-1:0] exp;
    } stage_t;

endpackage

// File: rtl/fpn_normalize_pipe_if.sv
// rtl/fpn_normalize_pipe_if.sv - input/output handshake bundle of the normaliser
interface fpn_normalize_pipe_if
    import fpn_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [MANT_W+1:0] in_sum;
    logic [EXP_W-1:0]  in_exp;
    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_uflow;
    logic              out_oflow;

    modport master (
        output in_valid, in_sum, in_exp, out_ready,
        input  in_ready, out_valid, out_sign, out_mant, out_exp, out_zero, out_uflow, out_oflow
    );

    modport slave (
        input  in_valid, in_sum, in_exp, out_ready,
        output in_ready, out_valid, out_sign, out_mant, out_exp, out_zero, out_uflow, out_oflow
    );
endinterface

// File: rtl/fpn_normalize_pipe_lzc.sv
// rtl/fpn_normalize_pipe_lzc.sv - combinational leading-zero counter with all-zero flag
module fpn_lzc
    import fpn_pkg::*;
#(
    parameter int W  = SUM_W,
    parameter int CW = SHIFT_W
) (
    input  logic [W-1:0]  data,
    output logic [CW-1:0] count,
    output logic          all_zero
);
    // scan upward so the highest set bit sets the final count
    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            if (data[i]) begin
                count = CW'(W - 1 - i);
            end
        end
    end

    assign all_zero = (data == '0);
endmodule

// File: rtl/fpn_normalize_pipe.sv
// rtl/fpn_normalize_pipe.sv - two-stage significand normaliser; FPN_ROUND_EN adds round-to-nearest-even
module fpn_normalize_pipe
    import fpn_pkg::*;
#(
    parameter int MANT_W = MANT_W_DEF,
    parameter int EXP_W  = EXP_W_DEF
) (
    input logic                clk,
    input logic                rst_n,
    fpn_normalize_pipe_if.slave bus
);
    localparam int SW  = sum_w(MANT_W);
    localparam int SHW = shift_w(MANT_W);
    localparam int EIW = exp_iw(EXP_W);
    localparam logic signed [EIW-1:0] EXP_MAX  = EIW'(exp_sat(EXP_W));
    localparam logic signed [EIW-1:0] EXP_ZERO = '0;

    typedef struct packed {
        logic             sign;
        logic [SW-1:0]    mag;
        logic [EXP_W-1:0] exp;
    } s1_t;

    s1_t  s1;
    logic s1_valid;
    logic s1_load;
    logic s2_load;

    assign s2_load     = !bus.out_valid || bus.out_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.in_ready = rst_n && s1_load;

    logic [SW-1:0] neg_sum;
    assign neg_sum = -bus.in_sum;

    // stage 1: split the two's-complement sum into sign and magnitude
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1       <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1.sign <= bus.in_sum[SW-1];
                s1.mag  <= bus.in_sum[SW-1] ? neg_sum : bus.in_sum;
                s1.exp  <= bus.in_exp;
            end
        end
    end

    logic [SHW-1:0] lz;
    logic           mag_zero;

    fpn_lzc #(.W(SW), .CW(SHW)) u_lzc (
        .data     (s1.mag),
        .count    (lz),
        .all_zero (mag_zero)
    );

    // shifting by lz puts the leading one at the top; the two bits below the
    // mantissa field are what a right shift by one or two would drop
    logic [SW-1:0]            norm;
    logic [MANT_W-1:0]        mant_t;
    logic signed [EIW-1:0]    exp_adj;
    logic [MANT_W-1:0]        mant_n;
    logic signed [EIW-1:0]    exp_n;

    assign norm    = s1.mag << lz;
    assign mant_t  = norm[SW-1:2];
    assign exp_adj = $signed(EIW'(s1.exp) + EIW'(2) - EIW'(lz));

`ifdef FPN_ROUND_EN
    logic              guard;
    logic              sticky;
    logic              round_up;
    logic [MANT_W:0]   mant_inc;

    assign guard    = norm[1];
    assign sticky   = norm[0];
    assign round_up = guard & (sticky | mant_t[0]);
    assign mant_inc = {1'b0, mant_t} + {{MANT_W{1'b0}}, round_up};
    assign mant_n   = mant_inc[MANT_W] ? {1'b1, {(MANT_W-1){1'b0}}} : mant_inc[MANT_W-1:0];
    assign exp_n    = exp_adj + EIW'(mant_inc[MANT_W]);
`else
    logic unused_dropped;
    assign unused_dropped = ^norm[1:0];
    assign mant_n         = mant_t;
    assign exp_n          = exp_adj;
`endif

    logic              res_sign;
    logic [MANT_W-1:0] res_mant;
    logic [EXP_W-1:0]  res_exp;
    logic              res_zero;
    logic              res_uflow;
    logic              res_oflow;

    // exception selection, zero outranks overflow outranks underflow
    always_comb begin
        res_sign  = s1.sign;
        res_mant  = mant_n;
        res_exp   = exp_n[EXP_W-1:0];
        res_zero  = 1'b0;
        res_uflow = 1'b0;
        res_oflow = 1'b0;
        if (mag_zero) begin
            res_sign = 1'b0;
            res_mant = '0;
            res_exp  = '0;
            res_zero = 1'b1;
        end else if (exp_n >= EXP_MAX) begin
            res_mant  = '0;
            res_exp   = '1;
            res_oflow = 1'b1;
        end else if (exp_n <= EXP_ZERO) begin
            res_mant  = '0;
            res_exp   = '0;
            res_uflow = 1'b1;
        end
    end

    // stage 2: output registers, held while downstream stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_sign  <= 1'b0;
            bus.out_mant  <= '0;
            bus.out_exp   <= '0;
            bus.out_zero  <= 1'b0;
            bus.out_uflow <= 1'b0;
            bus.out_oflow <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_sign  <= res_sign;
                bus.out_mant  <= res_mant;
                bus.out_exp   <= res_exp;
                bus.out_zero  <= res_zero;
                bus.out_uflow <= res_uflow;
                bus.out_oflow <= res_oflow;
            end
        end
    end
endmodule
